traffic_signal_controller: RTL and testbench

TRAFFIC_SIGNAL_CONTROLLER -- requirements
Module: traffic_signal_controller

---
 rtl/traffic_pkg.sv | 32 +++
 rtl/ped_request_latch.sv | 34 +++
 rtl/traffic_signal_controller.sv | 148 ++++++++++++++
 tb/tb_traffic_signal_controller.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// -----------------------------------------------------------------------------
// traffic_pkg
// Shared definitions for the crossing controller and pedestrian_signal:
//   - tsc_state_e : controller state encoding (also exported on state_o)
//   - *_DEF       : default phase durations in clock cycles
//   - last_cycle(): counter value of the final cycle of a phase of given length
// -----------------------------------------------------------------------------
package traffic_pkg;

    localparam int PHASE_W = 16;

    typedef enum logic [2:0] {
        GREEN   = 3'd0,
        YELLOW  = 3'd1,
        ALL_RED = 3'd2,
        WALK    = 3'd3,
        CLEAR   = 3'd4
    } tsc_state_e;

    // Default durations; every duration must be 1..65535 (zero is illegal).
    localparam logic [PHASE_W-1:0] GREEN_MIN_DEF = 16'd400;
    localparam logic [PHASE_W-1:0] YELLOW_T_DEF  = 16'd60;
    localparam logic [PHASE_W-1:0] ALLRED_T_DEF  = 16'd20;
    localparam logic [PHASE_W-1:0] WALK_MAX_DEF  = 16'd1000;

    // The phase counter is 0 on the first cycle of a phase, so a phase of
    // length dur ends on the cycle where the counter equals dur-1.
    function automatic logic [PHASE_W-1:0] last_cycle(input logic [PHASE_W-1:0] dur);
        return dur - 16'd1;
    endfunction

endpackage

// File: rtl/ped_request_latch.sv
// -----------------------------------------------------------------------------
// ped_request_latch
// Registered crossing-request flag.
//   clk     : clock, rising edge
//   rst_n   : asynchronous active-low reset, clears pending
//   set     : raise pending at the next edge
//   clear   : drop pending at the next edge (wins over set)
//   pending : registered request flag
// -----------------------------------------------------------------------------
module ped_request_latch (
    input  logic clk,
    input  logic rst_n,
    input  logic set,
    input  logic clear,
    output logic pending
);

    logic pending_reg;

    // Clear has priority: a request arriving on the very edge the crossing
    // starts is already being served by that crossing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_reg <= 1'b0;
        end else if (clear) begin
            pending_reg <= 1'b0;
        end else if (set) begin
            pending_reg <= 1'b1;
        end
    end

    assign pending = pending_reg;

endmodule

// File: rtl/traffic_signal_controller.sv
// -----------------------------------------------------------------------------
// traffic_signal_controller
// Vehicle / pedestrian crossing sequencer:
//   GREEN -> YELLOW -> ALL_RED -> WALK -> CLEAR -> GREEN
// GREEN is left only once a crossing request is pending and the minimum green
// time has elapsed. WALK ends on ped_done or, failing that, on a timeout that
// sets the sticky ped_fault flag.
// Parameters (cycles, each 1..65535):
//   GREEN_MIN, YELLOW_T, ALLRED_T (used before and after WALK), WALK_MAX
// Ports:
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   ped_button : crossing request, any pulse width
//   ped_done   : one-cycle pulse, crossing finished (only observed in WALK)
//   walk_grant : pedestrian_signal may show WALK
//   car_green / car_yellow / car_red : vehicle lamps, exactly one high
//   ped_fault  : sticky, a WALK phase ended by timeout (cleared by reset only)
//   state_o    : current state encoding, debug
// -----------------------------------------------------------------------------
module traffic_signal_controller
    import traffic_pkg::*;
#(
    parameter logic [15:0] GREEN_MIN = GREEN_MIN_DEF,
    parameter logic [15:0] YELLOW_T  = YELLOW_T_DEF,
    parameter logic [15:0] ALLRED_T  = ALLRED_T_DEF,
    parameter logic [15:0] WALK_MAX  = WALK_MAX_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ped_button,
    input  logic       ped_done,
    output logic       walk_grant,
    output logic       car_green,
    output logic       car_yellow,
    output logic       car_red,
    output logic       ped_fault,
    output logic [2:0] state_o
);

    tsc_state_e         state_reg;
    tsc_state_e         state_next;
    logic [PHASE_W-1:0] phase_cnt_reg;
    logic [PHASE_W-1:0] phase_cnt_next;
    logic               ped_fault_reg;
    logic               fault_set;
    logic               pending;
    logic               req_set;
    logic               req_clear;

    // -------------------------------------------------------------------------
    // Request latch: requests are ignored while the crossing is in progress
    // and consumed on entry to WALK.
    // -------------------------------------------------------------------------
    assign req_set   = ped_button && (state_reg != WALK);
    assign req_clear = (state_reg != WALK) && (state_next == WALK);

    ped_request_latch u_req (
        .clk     (clk),
        .rst_n   (rst_n),
        .set     (req_set),
        .clear   (req_clear),
        .pending (pending)
    );

    // -------------------------------------------------------------------------
    // State, phase counter and fault flag registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= GREEN;
            phase_cnt_reg <= '0;
            ped_fault_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            phase_cnt_reg <= phase_cnt_next;
            if (fault_set) begin
                ped_fault_reg <= 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        fault_set  = 1'b0;
        case (state_reg)
            GREEN: begin
                if (pending && (phase_cnt_reg >= last_cycle(GREEN_MIN))) begin
                    state_next = YELLOW;
                end
            end
            YELLOW: begin
                if (phase_cnt_reg == last_cycle(YELLOW_T)) begin
                    state_next = ALL_RED;
                end
            end
            ALL_RED: begin
                if (phase_cnt_reg == last_cycle(ALLRED_T)) begin
                    state_next = WALK;
                end
            end
            WALK: begin
                // ped_done takes precedence over a coincident timeout, so the
                // fault flag is only raised when the crossing truly overran.
                if (ped_done) begin
                    state_next = CLEAR;
                end else if (phase_cnt_reg == last_cycle(WALK_MAX)) begin
                    state_next = CLEAR;
                    fault_set  = 1'b1;
                end
            end
            CLEAR: begin
                if (phase_cnt_reg == last_cycle(ALLRED_T)) begin
                    state_next = GREEN;
                end
            end
            default: begin
                state_next = GREEN;
            end
        endcase
    end

    // Counter restarts on every state change. It saturates instead of wrapping
    // so that a very long idle GREEN still satisfies the minimum-green test.
    always_comb begin
        phase_cnt_next = phase_cnt_reg;
        if (state_next != state_reg) begin
            phase_cnt_next = '0;
        end else if (phase_cnt_reg != {PHASE_W{1'b1}}) begin
            phase_cnt_next = phase_cnt_reg + 16'd1;
        end
    end

    // -------------------------------------------------------------------------
    // Moore outputs, decoded straight from the state register so that reset
    // forces them immediately. car_red is the complement of the other two
    // lamps, keeping exactly one lamp lit even for unused encodings.
    // -------------------------------------------------------------------------
    assign car_green  = (state_reg == GREEN);
    assign car_yellow = (state_reg == YELLOW);
    assign car_red    = !(car_green || car_yellow);
    assign walk_grant = (state_reg == WALK);
    assign ped_fault  = ped_fault_reg;
    assign state_o    = state_reg;

endmodule

// File: tb/tb_traffic_signal_controller.sv
// -----------------------------------------------------------------------------
// tb_traffic_signal_controller
// Table-driven bench. Each scenario is a per-cycle list of {button, done,
// expected state, expected fault}; the lamp pattern is derived from the
// expected state. Cycle k's inputs are driven on the falling edge before
// rising edge k, and the outputs seen in that half-cycle are the state of
// cycle k (cycle 0 = first rising edge after reset release).
// -----------------------------------------------------------------------------
module tb_traffic_signal_controller;
    import traffic_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ped_button = 1'b0;
    logic       ped_done = 1'b0;
    logic       walk_grant;
    logic       car_green;
    logic       car_yellow;
    logic       car_red;
    logic       ped_fault;
    logic [2:0] state_o;

    always #5 clk = ~clk;

    traffic_signal_controller #(
        .GREEN_MIN (16'd4),
        .YELLOW_T  (16'd2),
        .ALLRED_T  (16'd1),
        .WALK_MAX  (16'd8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ped_button (ped_button),
        .ped_done   (ped_done),
        .walk_grant (walk_grant),
        .car_green  (car_green),
        .car_yellow (car_yellow),
        .car_red    (car_red),
        .ped_fault  (ped_fault),
        .state_o    (state_o)
    );

    localparam logic [2:0] SG = 3'd0;
    localparam logic [2:0] SY = 3'd1;
    localparam logic [2:0] SA = 3'd2;
    localparam logic [2:0] SW = 3'd3;
    localparam logic [2:0] SC = 3'd4;

    typedef struct {
        logic       btn;
        logic       done;
        logic [2:0] st;
        logic       fault;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Expected {state, green, yellow, red, walk, fault}
    function automatic logic [7:0] model_out(input logic [2:0] st, input logic f);
        logic g;
        logic y;
        logic r;
        logic w;
        g = (st == SG);
        y = (st == SY);
        r = (st == SA) || (st == SW) || (st == SC);
        w = (st == SW);
        return {st, g, y, r, w, f};
    endfunction

    function automatic logic [7:0] dut_out();
        return {state_o, car_green, car_yellow, car_red, walk_grant, ped_fault};
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got st/g/y/r/w/f=%b expected %b", name, act, exp);
        end
    endtask

    task automatic seg(input int n, input logic [2:0] st, input logic f);
        vec_t v;
        v.btn = 1'b0;
        v.done = 1'b0;
        v.st = st;
        v.fault = f;
        repeat (n) vecs.push_back(v);
    endtask

    task automatic mark(input int k, input logic btn, input logic done);
        vec_t v;
        v = vecs[k];
        v.btn = v.btn | btn;
        v.done = v.done | done;
        vecs[k] = v;
    endtask

    // Reset asserted asynchronously, checked before any clock edge, then
    // released on a falling edge so the next rising edge is cycle 0.
    task automatic do_reset();
        @(negedge clk);
        ped_button = 1'b0;
        ped_done   = 1'b0;
        rst_n      = 1'b0;
        #1;
        check("reset_state", dut_out(), model_out(SG, 1'b0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        vecs.delete();
    endtask

    task automatic run(input string name);
        int lamps;
        for (int k = 0; k < vecs.size(); k++) begin
            ped_button = vecs[k].btn;
            ped_done   = vecs[k].done;
            #1;
            $display("%s cyc %0d btn=%b done=%b -> st=%0d g%b y%b r%b w%b f%b",
                     name, k, ped_button, ped_done, state_o, car_green,
                     car_yellow, car_red, walk_grant, ped_fault);
            check($sformatf("%s_cyc%0d", name, k), dut_out(),
                  model_out(vecs[k].st, vecs[k].fault));
            lamps = int'(car_green) + int'(car_yellow) + int'(car_red);
            n_checks++;
            if (lamps != 1 || (walk_grant && !car_red)) begin
                n_fail++;
                $display("FAIL %s_lamps_cyc%0d: got lamps=%0d walk=%b red=%b required one lamp, walk->red",
                         name, k, lamps, walk_grant, car_red);
            end
            @(negedge clk);
        end
        ped_button = 1'b0;
        ped_done   = 1'b0;
    endtask

    initial begin
        // Idle: no request, GREEN forever
        do_reset();
        seg(50, SG, 1'b0);
        run("idle");

        // Normal crossing ended by ped_done
        do_reset();
        seg(4, SG, 0); seg(2, SY, 0); seg(1, SA, 0); seg(4, SW, 0);
        seg(1, SC, 0); seg(6, SG, 0);
        mark(1, 1, 0); mark(10, 0, 1);
        run("normal");

        // Crossing times out, fault is sticky
        do_reset();
        seg(4, SG, 0); seg(2, SY, 0); seg(1, SA, 0); seg(8, SW, 0);
        seg(1, SC, 1); seg(8, SG, 1);
        mark(1, 1, 0);
        run("timeout");

        // Button during WALK is ignored: GREEN holds afterwards
        do_reset();
        seg(4, SG, 0); seg(2, SY, 0); seg(1, SA, 0); seg(4, SW, 0);
        seg(1, SC, 0); seg(20, SG, 0);
        mark(1, 1, 0); mark(8, 1, 0); mark(10, 0, 1);
        run("walk_btn");

        // Button during CLEAR is served in the following GREEN
        do_reset();
        seg(4, SG, 0); seg(2, SY, 0); seg(1, SA, 0); seg(4, SW, 0);
        seg(1, SC, 0); seg(4, SG, 0); seg(2, SY, 0); seg(1, SA, 0);
        seg(2, SW, 0);
        mark(1, 1, 0); mark(8, 1, 0); mark(10, 0, 1); mark(11, 1, 0);
        run("clear_btn");

        // ped_done outside WALK has no effect
        do_reset();
        seg(4, SG, 0); seg(2, SY, 0); seg(1, SA, 0); seg(3, SW, 0);
        seg(1, SC, 0); seg(3, SG, 0);
        mark(1, 1, 0); mark(2, 0, 1); mark(5, 0, 1); mark(6, 0, 1);
        mark(9, 0, 1); mark(10, 0, 1); mark(11, 0, 1);
        run("done_ignored");

        // ped_done coincident with timeout: done wins, no fault
        do_reset();
        seg(4, SG, 0); seg(2, SY, 0); seg(1, SA, 0); seg(8, SW, 0);
        seg(1, SC, 0); seg(3, SG, 0);
        mark(1, 1, 0); mark(14, 0, 1);
        run("done_at_timeout");

        // Reset in the middle of WALK (cycle 9) acts without a clock edge
        do_reset();
        seg(4, SG, 0); seg(2, SY, 0); seg(1, SA, 0); seg(2, SW, 0);
        mark(1, 1, 0);
        run("mid_walk");
        #1;
        check("mid_walk_cyc9_before_reset", dut_out(), model_out(SW, 1'b0));
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_walk_async_reset", dut_out(), model_out(SG, 1'b0));
        @(negedge clk);
        check("mid_walk_reset_held", dut_out(), model_out(SG, 1'b0));
        rst_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
